// File: rtl/resp_merger_if.sv
// Shared types and the meta+data response stream interface used on every
// resp_merger port. The source side is the master; the sink side is the slave.
package resp_merger_pkg;
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

    typedef enum logic {
        META_ARB  = 1'b0,
        DATA_PASS = 1'b1
    } merger_state_e;
endpackage

// Valid/ready: a beat transfers on any cycle where val and rdy are both 1.
// A master holds val and its payload stable until the beat transfers.
// rdy may depend on val.
interface resp_merger_if #(
    parameter int NOC_DATA_W     = -1,
    parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
);
    import resp_merger_pkg::*;

    logic                      meta_val;
    udp_info                   meta_info;
    logic                      meta_rdy;
    logic                      data_val;
    logic [NOC_DATA_W-1:0]     data;
    logic                      data_last;
    logic [NOC_PADBYTES_W-1:0] data_padbytes;
    logic                      data_rdy;

    modport master (
        output meta_val, meta_info, data_val, data, data_last, data_padbytes,
        input  meta_rdy, data_rdy
    );

    modport slave (
        input  meta_val, meta_info, data_val, data, data_last, data_padbytes,
        output meta_rdy, data_rdy
    );
endinterface

// File: rtl/resp_merger.sv
// Merges the setup and manage response streams into one UDP TX stream.
// Arbitration is round-robin per packet; the winner is held until its last data beat.
module resp_merger
    import resp_merger_pkg::*;
#(
    parameter int NOC_DATA_W     = -1,
    parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
    input  logic          clk,
    input  logic          rst,
    resp_merger_if.slave  setup_merger,
    resp_merger_if.slave  manage_merger,
    resp_merger_if.master merger_udp,
    output merger_state_e dbg_state
);

    merger_state_e state;
    logic          sel_reg;
    logic          prio_reg;
    logic          lock_reg;
    logic          sel_next;

    logic                      in_meta;
    logic                      in_data;
    logic                      meta_val_sel;
    udp_info                   meta_info_sel;
    logic                      data_val_sel;
    logic [NOC_DATA_W-1:0]     data_sel;
    logic                      data_last_sel;
    logic [NOC_PADBYTES_W-1:0] padbytes_sel;
    logic                      meta_val_out;
    logic                      data_val_out;
    logic                      meta_hs;
    logic                      data_hs_last;

    assign in_meta = (state == META_ARB);
    assign in_data = (state == DATA_PASS);

    // A locked meta grant keeps the offered output stable until it is accepted.
    always_comb begin
        sel_next = sel_reg;
        if (in_meta && !lock_reg) begin
            case ({manage_merger.meta_val, setup_merger.meta_val})
                2'b01:   sel_next = 1'b0;
                2'b10:   sel_next = 1'b1;
                2'b11:   sel_next = prio_reg;
                default: sel_next = sel_reg;
            endcase
        end
    end

    always_comb begin
        if (sel_next) begin
            meta_val_sel  = manage_merger.meta_val;
            meta_info_sel = manage_merger.meta_info;
            data_val_sel  = manage_merger.data_val;
            data_sel      = manage_merger.data;
            data_last_sel = manage_merger.data_last;
            padbytes_sel  = manage_merger.data_padbytes;
        end else begin
            meta_val_sel  = setup_merger.meta_val;
            meta_info_sel = setup_merger.meta_info;
            data_val_sel  = setup_merger.data_val;
            data_sel      = setup_merger.data;
            data_last_sel = setup_merger.data_last;
            padbytes_sel  = setup_merger.data_padbytes;
        end
    end

    assign meta_val_out = in_meta & meta_val_sel;
    assign data_val_out = in_data & data_val_sel;
    assign meta_hs      = meta_val_out & merger_udp.meta_rdy;
    assign data_hs_last = data_val_out & merger_udp.data_rdy & data_last_sel;

    assign merger_udp.meta_val      = meta_val_out;
    assign merger_udp.meta_info     = meta_info_sel;
    assign merger_udp.data_val      = data_val_out;
    assign merger_udp.data          = data_sel;
    assign merger_udp.data_last     = data_last_sel;
    assign merger_udp.data_padbytes = padbytes_sel;

    // Meta ready is qualified by the source's own valid so an idle block shows rdy = 0.
    assign setup_merger.meta_rdy  = in_meta & ~sel_next & setup_merger.meta_val
                                    & merger_udp.meta_rdy;
    assign manage_merger.meta_rdy = in_meta &  sel_next & manage_merger.meta_val
                                    & merger_udp.meta_rdy;
    assign setup_merger.data_rdy  = in_data & ~sel_reg & merger_udp.data_rdy;
    assign manage_merger.data_rdy = in_data &  sel_reg & merger_udp.data_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= META_ARB;
            sel_reg  <= 1'b0;
            prio_reg <= 1'b0;
            lock_reg <= 1'b0;
        end else begin
            case (state)
                META_ARB: begin
                    if (meta_hs) begin
                        sel_reg  <= sel_next;
                        lock_reg <= 1'b0;
                        prio_reg <= ~sel_next;
                        state    <= DATA_PASS;
                    end else if (meta_val_out) begin
                        sel_reg  <= sel_next;
                        lock_reg <= 1'b1;
                    end
                end
                DATA_PASS: begin
                    if (data_hs_last) begin
                        state <= META_ARB;
                    end
                end
                default: state <= META_ARB;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_resp_merger.sv
// Directed bench for resp_merger: single packet, fairness, meta lock,
// data backpressure, early data and mid-packet reset.
module tb_resp_merger;
    import resp_merger_pkg::*;

    localparam int DW = 64;

    logic          clk;
    logic          rst;
    merger_state_e dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];

    resp_merger_if #(.NOC_DATA_W(DW)) s_if ();
    resp_merger_if #(.NOC_DATA_W(DW)) m_if ();
    resp_merger_if #(.NOC_DATA_W(DW)) u_if ();

    resp_merger #(.NOC_DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .setup_merger  (s_if),
        .manage_merger (m_if),
        .merger_udp    (u_if),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic src_idle();
        s_if.meta_val = 1'b0; s_if.meta_info = '0; s_if.data_val = 1'b0;
        s_if.data = '0; s_if.data_last = 1'b0; s_if.data_padbytes = '0;
        m_if.meta_val = 1'b0; m_if.meta_info = '0; m_if.data_val = 1'b0;
        m_if.data = '0; m_if.data_last = 1'b0; m_if.data_padbytes = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic udp_info mk_info(input logic [15:0] port);
        udp_info i;
        i = '0;
        i.src_ip   = 32'h0A00_0001;
        i.dst_ip   = 32'h0A00_0002;
        i.src_port = 16'h0050;
        i.dst_port = port;
        return i;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_s_mrdy"}, 64'(s_if.meta_rdy), 64'd0);
        chk({tag, "_m_mrdy"}, 64'(m_if.meta_rdy), 64'd0);
        chk({tag, "_s_drdy"}, 64'(s_if.data_rdy), 64'd0);
        chk({tag, "_m_drdy"}, 64'(m_if.data_rdy), 64'd0);
        chk({tag, "_u_mval"}, 64'(u_if.meta_val), 64'd0);
        chk({tag, "_u_dval"}, 64'(u_if.data_val), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic          exp_m;
        logic [15:0]   exp_port;
        logic [31:0]   val_pat;
        logic [31:0]   rdy_pat;
        logic [DW-1:0] exp_d;
        int            s_cnt;
        int            m_cnt;
        int            beat;

        rst = 1'b1;
        src_idle();
        u_if.meta_rdy = 1'b0;
        u_if.data_rdy = 1'b0;
        do_reset();
        u_if.meta_rdy = 1'b1;
        u_if.data_rdy = 1'b1;
        settle();
        chk("rst_state", 64'(dbg_state), 64'(META_ARB));
        chk_quiet("rst");

        // Setup-only packet: meta then 3 beats, padbytes 5 on the last
        s_if.meta_val  = 1'b1;
        s_if.meta_info = mk_info(16'h1234);
        settle();
        chk("t1_u_mval", 64'(u_if.meta_val), 64'd1);
        chk("t1_port", 64'(u_if.meta_info.dst_port), 64'h1234);
        chk("t1_s_mrdy", 64'(s_if.meta_rdy), 64'd1);
        chk("t1_m_mrdy", 64'(m_if.meta_rdy), 64'd0);
        chk("t1_u_dval0", 64'(u_if.data_val), 64'd0);
        chk("t1_s_drdy0", 64'(s_if.data_rdy), 64'd0);
        tick();
        s_if.meta_val = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_if.data_val      = 1'b1;
            s_if.data          = 64'hA0 + 64'(b);
            s_if.data_last     = (b == 2);
            s_if.data_padbytes = (b == 2) ? 3'd5 : 3'd0;
            settle();
            chk("t1_state", 64'(dbg_state), 64'(DATA_PASS));
            chk("t1_u_dval", 64'(u_if.data_val), 64'd1);
            chk("t1_data", 64'(u_if.data), 64'hA0 + 64'(b));
            chk("t1_last", 64'(u_if.data_last), 64'(b == 2));
            chk("t1_s_drdy", 64'(s_if.data_rdy), 64'd1);
            chk("t1_m_drdy", 64'(m_if.data_rdy), 64'd0);
            chk("t1_m_mrdy_d", 64'(m_if.meta_rdy), 64'd0);
            chk("t1_u_mval_d", 64'(u_if.meta_val), 64'd0);
            if (b == 2) chk("t1_pad", 64'(u_if.data_padbytes), 64'd5);
            tick();
        end
        src_idle();
        settle();
        chk("t1_back_arb", 64'(dbg_state), 64'(META_ARB));

        // Continuous contention: grants alternate S, M, S, M ...
        do_reset();
        s_cnt = 0;
        m_cnt = 0;
        s_if.meta_val = 1'b1;
        m_if.meta_val = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_if.meta_info = mk_info(16'h5000 + 16'(s_cnt));
            m_if.meta_info = mk_info(16'h6000 + 16'(m_cnt));
            s_if.data_val  = 1'b0;
            m_if.data_val  = 1'b0;
            exp_m    = k[0];
            exp_port = exp_m ? 16'h6000 + 16'(k / 2) : 16'h5000 + 16'(k / 2);
            settle();
            chk("t2_port", 64'(u_if.meta_info.dst_port), 64'(exp_port));
            chk("t2_s_mrdy", 64'(s_if.meta_rdy), 64'(!exp_m));
            chk("t2_m_mrdy", 64'(m_if.meta_rdy), 64'(exp_m));
            tick();
            s_if.data_val = 1'b1; s_if.data = 64'h5D00 + 64'(s_cnt); s_if.data_last = 1'b1;
            m_if.data_val = 1'b1; m_if.data = 64'h6D00 + 64'(m_cnt); m_if.data_last = 1'b1;
            settle();
            exp_d = exp_m ? 64'h6D00 + 64'(k / 2) : 64'h5D00 + 64'(k / 2);
            chk("t2_data", 64'(u_if.data), 64'(exp_d));
            chk("t2_s_drdy", 64'(s_if.data_rdy), 64'(!exp_m));
            chk("t2_m_drdy", 64'(m_if.data_rdy), 64'(exp_m));
            if (s_if.data_rdy) s_cnt++;
            if (m_if.data_rdy) m_cnt++;
            tick();
        end
        src_idle();

        // Meta backpressure: manage offered first must not be displaced
        u_if.meta_rdy  = 1'b0;
        m_if.meta_val  = 1'b1;
        m_if.meta_info = mk_info(16'h7777);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                s_if.meta_val  = 1'b1;
                s_if.meta_info = mk_info(16'h8888);
            end
            settle();
            chk("t3_u_mval", 64'(u_if.meta_val), 64'd1);
            chk("t3_port", 64'(u_if.meta_info.dst_port), 64'h7777);
            chk("t3_m_mrdy", 64'(m_if.meta_rdy), 64'd0);
            chk("t3_s_mrdy", 64'(s_if.meta_rdy), 64'd0);
            tick();
        end
        u_if.meta_rdy = 1'b1;
        settle();
        chk("t3_grant_port", 64'(u_if.meta_info.dst_port), 64'h7777);
        chk("t3_grant_m", 64'(m_if.meta_rdy), 64'd1);
        chk("t3_grant_s", 64'(s_if.meta_rdy), 64'd0);
        tick();
        m_if.meta_val  = 1'b0;
        m_if.data_val  = 1'b1;
        m_if.data      = 64'h77;
        m_if.data_last = 1'b1;
        settle();
        chk("t3_m_data", 64'(u_if.data), 64'h77);
        chk("t3_m_drdy", 64'(m_if.data_rdy), 64'd1);
        tick();

        // 10-beat setup packet with bubbles and backpressure; manage keeps pushing
        m_if.meta_val  = 1'b1;
        m_if.meta_info = mk_info(16'h9999);
        m_if.data      = 64'hBAD;
        settle();
        chk("t4_port", 64'(u_if.meta_info.dst_port), 64'h8888);
        chk("t4_s_mrdy", 64'(s_if.meta_rdy), 64'd1);
        tick();
        s_if.meta_val = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(64'h100 + 64'(i));
        val_pat = 32'b1101_1011_0111_1110_1101_1111_1011_1111;
        rdy_pat = 32'b1011_1110_1101_1011_1111_0111_1010_1101;
        beat = 0;
        for (int c = 0; c < 32 && beat < 10; c++) begin
            s_if.data_val  = val_pat[c];
            s_if.data      = 64'h100 + 64'(beat);
            s_if.data_last = (beat == 9);
            u_if.data_rdy  = rdy_pat[c];
            settle();
            chk("t4_u_dval", 64'(u_if.data_val), 64'(val_pat[c]));
            chk("t4_s_drdy", 64'(s_if.data_rdy), 64'(rdy_pat[c]));
            chk("t4_m_drdy", 64'(m_if.data_rdy), 64'd0);
            if (s_if.data_val && s_if.data_rdy) begin
                chk("t4_beat", 64'(u_if.data), 64'(exp_q.pop_front()));
                chk("t4_last", 64'(u_if.data_last), 64'(beat == 9));
                beat++;
            end
            tick();
        end
        chk("t4_beats", 64'(beat), 64'd10);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
        s_if.data_val  = 1'b0;
        s_if.data_last = 1'b0;
        u_if.data_rdy  = 1'b1;
        settle();
        chk("t4_arb", 64'(dbg_state), 64'(META_ARB));
        chk("t4_m_port", 64'(u_if.meta_info.dst_port), 64'h9999);
        chk("t4_m_mrdy", 64'(m_if.meta_rdy), 64'd1);
        tick();
        m_if.meta_val = 1'b0;
        settle();
        chk("t4_m_data", 64'(u_if.data), 64'hBAD);
        chk("t4_m_drdy_ok", 64'(m_if.data_rdy), 64'd1);
        tick();
        src_idle();

        // Early data: manage data waits for its meta handshake
        do_reset();
        m_if.data_val  = 1'b1;
        m_if.data      = 64'hE0;
        m_if.data_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t5_m_drdy_early", 64'(m_if.data_rdy), 64'd0);
            chk("t5_u_dval_early", 64'(u_if.data_val), 64'd0);
            tick();
        end
        m_if.meta_val  = 1'b1;
        m_if.meta_info = mk_info(16'h5555);
        settle();
        chk("t5_m_mrdy", 64'(m_if.meta_rdy), 64'd1);
        chk("t5_m_drdy_meta", 64'(m_if.data_rdy), 64'd0);
        chk("t5_u_dval_meta", 64'(u_if.data_val), 64'd0);
        tick();
        m_if.meta_val = 1'b0;
        settle();
        chk("t5_m_drdy", 64'(m_if.data_rdy), 64'd1);
        chk("t5_u_dval", 64'(u_if.data_val), 64'd1);
        chk("t5_data", 64'(u_if.data), 64'hE0);
        tick();
        src_idle();

        // Reset in DATA_PASS after 2 of 4 beats
        s_if.meta_val  = 1'b1;
        s_if.meta_info = mk_info(16'h4444);
        settle();
        chk("t6_s_mrdy", 64'(s_if.meta_rdy), 64'd1);
        tick();
        s_if.meta_val = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_if.data_val = 1'b1;
            s_if.data     = 64'hC0 + 64'(b);
            settle();
            chk("t6_data", 64'(u_if.data), 64'hC0 + 64'(b));
            chk("t6_s_drdy", 64'(s_if.data_rdy), 64'd1);
            tick();
        end
        s_if.data = 64'hC2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_idle();
        settle();
        chk("t6_rst_state", 64'(dbg_state), 64'(META_ARB));
        chk_quiet("t6_rst");
        tick();
        s_if.meta_val  = 1'b1;
        s_if.meta_info = mk_info(16'h4545);
        m_if.meta_val  = 1'b1;
        m_if.meta_info = mk_info(16'h4646);
        settle();
        chk("t6_prio_port", 64'(u_if.meta_info.dst_port), 64'h4545);
        chk("t6_prio_s", 64'(s_if.meta_rdy), 64'd1);
        tick();
        s_if.meta_val  = 1'b0;
        m_if.meta_val  = 1'b0;
        s_if.data_val  = 1'b1;
        s_if.data      = 64'hF0;
        s_if.data_last = 1'b1;
        settle();
        chk("t6_new_data", 64'(u_if.data), 64'hF0);
        chk("t6_new_drdy", 64'(s_if.data_rdy), 64'd1);
        tick();
        src_idle();
        settle();
        chk("t6_end_state", 64'(dbg_state), 64'(META_ARB));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
